// File: rtl/inst_fetch_axi.sv
// Instruction fetch stage: one AXI4-Lite read per enabled, word-aligned PC.
// The fetched word is returned with a one-cycle valid strobe. A stall is
// requested while the read is outstanding. A redirect (flush) that arrives
// mid-transaction lets the bus transaction finish and drops its result.
module inst_fetch_axi #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter logic [2:0]  AR_PROT = 3'b100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              fetch_err_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  output logic [2:0]        arprot,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;
  logic   discard;
  logic   aligned, start, misaligned, ar_hs, r_hs;

  assign arprot = AR_PROT;

  // Decode of request conditions and handshakes, plus the combinational stall.
  always_comb begin
    aligned    = (pc_i[1:0] == 2'b00);
    start      = (state == IDLE) && ce_i && aligned && !flush_i;
    misaligned = (state == IDLE) && ce_i && !aligned;
    ar_hs      = arvalid && arready;
    r_hs       = rvalid && rready;
    stallreq_o = start || (state == ADDR) || ((state == DATA) && !rvalid);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = ADDR;
      ADDR: if (ar_hs) state_nxt = DATA;
      DATA: if (r_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // AXI channel controls, discard tracking and the returned instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      araddr       <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
      discard      <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            araddr  <= pc_i;
            arvalid <= 1'b1;
          end else if (misaligned) begin
            inst_o       <= '0;
            fetch_err_o  <= 1'b1;
            inst_valid_o <= 1'b1;
          end
        end
        ADDR: begin
          if (flush_i) discard <= 1'b1;
          if (ar_hs) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        DATA: begin
          if (r_hs) begin
            rready  <= 1'b0;
            discard <= 1'b0;
            // A flush arriving together with the data still drops it.
            if (!discard && !flush_i) begin
              inst_o       <= (rresp == 2'b00) ? rdata : '0;
              fetch_err_o  <= (rresp != 2'b00);
              inst_valid_o <= 1'b1;
            end
          end else if (flush_i) begin
            discard <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch_axi.md
Name: inst_fetch_axi

Overview:
Instruction-fetch stage directly downstream of the program counter register. It turns each enabled PC value into a single-beat AXI4-Lite read on the instruction port and returns the fetched word with a one-cycle valid strobe for the IF/ID register. While the bus transaction is outstanding it raises a stall request so the PC register and the pipeline hold.

Parameters:
ADDR_W, 32, instruction address width; matches the PC width
DATA_W, 32, instruction word width; matches the AXI rdata width
AR_PROT, 3'b100, constant driven on arprot; marks the access as an instruction access

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
pc_i  in  ADDR_W  fetch address from the PC register
ce_i  in  1  fetch enable from the PC register; 0 means no fetch
flush_i  in  1  discard the fetch in flight (branch/exception redirect)
inst_o  out  DATA_W  fetched instruction; holds its value between fetches
inst_valid_o  out  1  one-cycle strobe: inst_o/fetch_err_o are valid this cycle
fetch_err_o  out  1  fetch fault flag; qualified by inst_valid_o
stallreq_o  out  1  stall request to the stall controller; combinational
araddr  out  ADDR_W  AXI read address; word aligned
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
arprot  out  3  constant AR_PROT
rdata  in  DATA_W  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready

Behaviour:
- Reset values: state=IDLE, arvalid=0, rready=0, araddr=0, inst_o=0, inst_valid_o=0, fetch_err_o=0, discard=0.
- States: IDLE, ADDR, DATA.
- IDLE: if ce_i=1 and pc_i[1:0]==0 and flush_i=0, latch araddr<=pc_i, set arvalid<=1, go to ADDR.
- IDLE, misaligned: if ce_i=1 and pc_i[1:0]!=0, issue no bus access; next cycle inst_valid_o=1, fetch_err_o=1, inst_o=0; stay in IDLE.
- ADDR: arvalid and araddr stay stable until arready. On arvalid&&arready, clear arvalid, set rready<=1, go to DATA.
- DATA: on rvalid&&rready, clear rready and go to IDLE.
  - If discard=0: inst_o<=rdata; fetch_err_o<=(rresp!=2'b00); inst_valid_o<=1 for the next cycle only. On an error response inst_o<=0.
  - Clear discard.
- stallreq_o = (state==IDLE && ce_i && pc_i aligned && !flush_i) || state==ADDR || (state==DATA && !rvalid). It is low in the cycle rvalid arrives, so the PC advances on that edge and the next IDLE cycle sees the new PC.
- Minimum latency: PC presented in IDLE (cycle 0), AR handshake in cycle 1 at the earliest, R handshake in cycle 2 at the earliest, inst_valid_o in cycle 3.
- Flush:
  - In IDLE: suppresses the start.
  - In ADDR or DATA: sets discard=1. The AXI transaction still completes (arvalid is never withdrawn), but no inst_valid_o is produced.
  - If flush and rvalid arrive in the same cycle, the data is discarded.
- ce_i=0 in IDLE: no activity, stallreq_o=0. Changes to ce_i or pc_i during ADDR/DATA are ignored.
- Reset mid-transaction: the block returns to IDLE immediately; the AXI slave shares rst.
- Exactly one outstanding read; no address or data is buffered beyond the current transaction.

Test Plan:
- Basic fetch: rst 2 cycles, then ce_i=1, pc_i=0x0, arready=1, rvalid=1 the cycle after AR with rdata=0x24080001 -> araddr=0x0 with arvalid 1 cycle; inst_o=0x24080001 with inst_valid_o one cycle; stallreq_o high for 2 cycles.
- Backpressure: arready low 3 cycles, then rvalid delayed 2 cycles -> arvalid and araddr stable throughout; stallreq_o stays high until the rvalid cycle; single valid strobe.
- Error response: rresp=2'b10 at pc 0x40 -> inst_o=0, fetch_err_o=1, inst_valid_o=1.
- Misaligned: pc_i=0x6 -> arvalid never asserts; next cycle inst_valid_o=1, fetch_err_o=1.
- Flush in flight: flush_i pulsed during DATA -> R handshake completes with rready, no inst_valid_o; the following fetch at a new pc returns normally.
- Reset mid-fetch: rst asserted in ADDR -> next cycle arvalid=0, rready=0, all outputs at reset values.
